// File: rtl/fire_lfsr_bank.sv
// Fire-code serial division bank: encoder E, syndromes C (x^15+1) and P (x^9+x^4+1).
// Optional FIRE_LFSR_COUNT_SAT_EN: C/P bit counters saturate instead of wrapping.
module fire_lfsr_bank #(
  parameter int N = 64,
  parameter int K = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [K-1:0] reg_e_in,
  input  logic [N-1:0] reg_c_in,
  input  logic [N-1:0] reg_p_in,
  input  logic         shift_e,
  input  logic         shift_c,
  input  logic         shift_p,
  output logic [23:0]  reg_e_out,
  output logic [14:0]  reg_c_out,
  output logic [8:0]   reg_p_out,
  output logic [5:0]   reg_e_count,
  output logic [7:0]   reg_c_count,
  output logic [10:0]  reg_p_count
);

  localparam logic [23:0] E_POLY = 24'h088211;

  // Buffers shift left as bits are consumed, so the MSB is always
  // the next bit and zeros appear naturally once the word runs out.
  logic         e_prev, c_prev, p_prev;
  logic [K-1:0] e_buf;
  logic [N-1:0] c_buf, p_buf;
  logic [23:0]  e_r;
  logic [14:0]  c_r;
  logic [8:0]   p_r;

  logic        e_start, e_run, e_bit, e_fb;
  logic [23:0] e_base;
  logic        c_start, c_run, c_bit;
  logic        p_start, p_run, p_bit;

  always_comb begin
    e_start = shift_e & ~e_prev;
    e_run   = shift_e & e_prev & (reg_e_count != 6'(K-1));
    e_bit   = e_start ? reg_e_in[K-1] : e_buf[K-1];
    e_base  = e_start ? '0 : e_r;
    e_fb    = e_bit ^ e_base[23];
    c_start = shift_c & ~c_prev;
    c_run   = shift_c & c_prev;
    c_bit   = c_start ? reg_c_in[N-1] : c_buf[N-1];
    p_start = shift_p & ~p_prev;
    p_run   = shift_p & p_prev;
    p_bit   = p_start ? reg_p_in[N-1] : p_buf[N-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_prev      <= 1'b0;
      e_buf       <= '0;
      e_r         <= '0;
      reg_e_count <= '0;
    end else begin
      e_prev <= shift_e;
      if (e_start) begin
        e_buf       <= {reg_e_in[K-2:0], 1'b0};
        reg_e_count <= '0;
      end else if (e_run) begin
        e_buf       <= {e_buf[K-2:0], 1'b0};
        reg_e_count <= reg_e_count + 6'd1;
      end
      if (e_start | e_run)
        e_r <= {e_base[22:0], 1'b0} ^ (e_fb ? E_POLY : 24'h0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_prev      <= 1'b0;
      c_buf       <= '0;
      c_r         <= '0;
      reg_c_count <= '0;
    end else begin
      c_prev <= shift_c;
      if (c_start) begin
        c_buf       <= {reg_c_in[N-2:0], 1'b0};
        c_r         <= {14'h0, c_bit};
        reg_c_count <= '0;
      end else if (c_run) begin
        c_buf <= {c_buf[N-2:0], 1'b0};
        c_r   <= {c_r[13:0], c_bit} ^ {14'h0, c_r[14]};
`ifdef FIRE_LFSR_COUNT_SAT_EN
        if (reg_c_count != 8'hff)
          reg_c_count <= reg_c_count + 8'd1;
`else
        reg_c_count <= reg_c_count + 8'd1;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_prev      <= 1'b0;
      p_buf       <= '0;
      p_r         <= '0;
      reg_p_count <= '0;
    end else begin
      p_prev <= shift_p;
      if (p_start) begin
        p_buf       <= {reg_p_in[N-2:0], 1'b0};
        p_r         <= {8'h0, p_bit};
        reg_p_count <= '0;
      end else if (p_run) begin
        p_buf <= {p_buf[N-2:0], 1'b0};
        p_r   <= {p_r[7:0], p_bit} ^ (p_r[8] ? 9'h011 : 9'h0);
`ifdef FIRE_LFSR_COUNT_SAT_EN
        if (reg_p_count != 11'h7ff)
          reg_p_count <= reg_p_count + 11'd1;
`else
        reg_p_count <= reg_p_count + 11'd1;
`endif
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 24; i++) reg_e_out[i] = e_r[23-i];
    for (int i = 0; i < 15; i++) reg_c_out[i] = c_r[14-i];
    for (int i = 0; i < 9; i++)  reg_p_out[i] = p_r[8-i];
  end

endmodule

// File: tb/tb_fire_lfsr_bank.sv
// Bench for fire_lfsr_bank: polynomial-remainder model checked every cycle
// plus directed literal checks.
module tb_fire_lfsr_bank;

  localparam int N = 64;
  localparam int K = 40;

  logic         clk = 0;
  logic         rst = 1;
  logic [K-1:0] reg_e_in = '0;
  logic [N-1:0] reg_c_in = '0;
  logic [N-1:0] reg_p_in = '0;
  logic         shift_e = 0, shift_c = 0, shift_p = 0;
  logic [23:0]  reg_e_out;
  logic [14:0]  reg_c_out;
  logic [8:0]   reg_p_out;
  logic [5:0]   reg_e_count;
  logic [7:0]   reg_c_count;
  logic [10:0]  reg_p_count;

  fire_lfsr_bank #(.N(N), .K(K)) dut (
    .clk(clk), .rst(rst),
    .reg_e_in(reg_e_in), .reg_c_in(reg_c_in), .reg_p_in(reg_p_in),
    .shift_e(shift_e), .shift_c(shift_c), .shift_p(shift_p),
    .reg_e_out(reg_e_out), .reg_c_out(reg_c_out), .reg_p_out(reg_p_out),
    .reg_e_count(reg_e_count), .reg_c_count(reg_c_count),
    .reg_p_count(reg_p_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Natural remainders as polynomials: R' = x*R + b*(x^24 mod g) for E,
  // R' = x*R + b mod g for C and P.
  function automatic logic [23:0] e_step(input logic [23:0] r, input logic b);
    logic [24:0] t;
    t = {r, 1'b0};
    if (t[24]) t = t ^ 25'h1088211;
    return t[23:0] ^ (b ? 24'h088211 : 24'h0);
  endfunction

  function automatic logic [14:0] c_step(input logic [14:0] r, input logic b);
    logic [15:0] t;
    t = {r, b};
    if (t[15]) t = t ^ 16'h8001;
    return t[14:0];
  endfunction

  function automatic logic [8:0] p_step(input logic [8:0] r, input logic b);
    logic [9:0] t;
    t = {r, b};
    if (t[9]) t = t ^ 10'h211;
    return t[8:0];
  endfunction

  function automatic logic wbit(input logic [63:0] w, input int width, input int idx);
    if (idx >= width) return 1'b0;
    return w[width-1-idx];
  endfunction

  function automatic int rev(input logic [23:0] v, input int w);
    int r = 0;
    for (int i = 0; i < w; i++) if (v[i]) r = r | (1 << (w-1-i));
    return r;
  endfunction

  function automatic int cnt_exp(input int idx, input int w);
`ifdef FIRE_LFSR_COUNT_SAT_EN
    return (idx > (1 << w) - 1) ? (1 << w) - 1 : idx;
`else
    return idx % (1 << w);
`endif
  endfunction

  logic        me_prev, mc_prev, mp_prev;
  logic [63:0] me_w, mc_w, mp_w;
  int          me_idx, mc_idx, mp_idx;
  logic [23:0] me_r;
  logic [14:0] mc_r;
  logic [8:0]  mp_r;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      me_prev <= 0; mc_prev <= 0; mp_prev <= 0;
      me_w <= 0; mc_w <= 0; mp_w <= 0;
      me_idx <= 0; mc_idx <= 0; mp_idx <= 0;
      me_r <= 0; mc_r <= 0; mp_r <= 0;
    end else begin
      me_prev <= shift_e;
      mc_prev <= shift_c;
      mp_prev <= shift_p;
      if (shift_e && !me_prev) begin
        me_w <= {24'h0, reg_e_in};
        me_idx <= 0;
        me_r <= e_step(24'h0, reg_e_in[K-1]);
      end else if (shift_e && me_idx < K-1) begin
        me_idx <= me_idx + 1;
        me_r <= e_step(me_r, wbit(me_w, K, me_idx + 1));
      end
      if (shift_c && !mc_prev) begin
        mc_w <= reg_c_in;
        mc_idx <= 0;
        mc_r <= c_step(15'h0, reg_c_in[N-1]);
      end else if (shift_c) begin
        mc_idx <= mc_idx + 1;
        mc_r <= c_step(mc_r, wbit(mc_w, N, mc_idx + 1));
      end
      if (shift_p && !mp_prev) begin
        mp_w <= reg_p_in;
        mp_idx <= 0;
        mp_r <= p_step(9'h0, reg_p_in[N-1]);
      end else if (shift_p) begin
        mp_idx <= mp_idx + 1;
        mp_r <= p_step(mp_r, wbit(mp_w, N, mp_idx + 1));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("model_e_out", int'(reg_e_out), rev(me_r, 24));
    chk("model_c_out", int'(reg_c_out), rev({9'h0, mc_r}, 15));
    chk("model_p_out", int'(reg_p_out), rev({15'h0, mp_r}, 9));
    chk("model_e_cnt", int'(reg_e_count), cnt_exp(me_idx, 6));
    chk("model_c_cnt", int'(reg_c_count), cnt_exp(mc_idx, 8));
    chk("model_p_cnt", int'(reg_p_count), cnt_exp(mp_idx, 11));
  end

  task automatic idle(input int n);
    shift_e = 0; shift_c = 0; shift_p = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic encode_check(input string tag);
    reg_e_in = 40'h1;
    shift_e = 1;
    repeat (41) @(negedge clk);
    chk({tag, "_e_cnt"}, int'(reg_e_count), 39);
    chk({tag, "_e_out"}, int'(reg_e_out), 24'h884110);
    idle(1);
  endtask

  initial begin
    #2;
    chk("rst_e_out", int'(reg_e_out), 0);
    chk("rst_c_out", int'(reg_c_out), 0);
    chk("rst_p_cnt", int'(reg_p_count), 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    encode_check("t1");

    reg_c_in = 64'h1; reg_p_in = 64'h1;
    shift_c = 1; shift_p = 1;
    repeat (64) @(negedge clk);
    chk("t2_c_cnt", int'(reg_c_count), 63);
    chk("t2_c_out", int'(reg_c_out), 15'h4000);
    chk("t2_p_out", int'(reg_p_out), 9'h100);
    shift_p = 0;
    @(negedge clk);
    chk("t2_c_extra", int'(reg_c_out), 15'h2000);
    idle(1);

    reg_c_in = 64'h8000_0000_0000_0000;
    shift_c = 1;
    repeat (64) @(negedge clk);
    chk("t3_c_msb", int'(reg_c_out), 15'h0800);
    idle(1);
    reg_c_in = '0; reg_p_in = '0;
    shift_c = 1; shift_p = 1;
    repeat (64) @(negedge clk);
    chk("t3_c_zero", int'(reg_c_out), 0);
    chk("t3_p_zero", int'(reg_p_out), 0);
    idle(1);

    reg_c_in = 64'h1;
    shift_c = 1;
    @(negedge clk);
    reg_c_in = '0;
    repeat (63) @(negedge clk);
    chk("t4_c_cnt", int'(reg_c_count), 63);
    chk("t4_c_out", int'(reg_c_out), 15'h4000);
    idle(1);

    reg_p_in = 64'hdead_beef_0123_4567;
    shift_p = 1;
    repeat (2100) @(negedge clk);
`ifdef FIRE_LFSR_COUNT_SAT_EN
    chk("t5_p_cnt", int'(reg_p_count), 2047);
`else
    chk("t5_p_cnt", int'(reg_p_count), 51);
`endif
    idle(1);

    reg_e_in = 40'hA5_5A00_FF01;
    reg_c_in = 64'h0123_4567_89ab_cdef;
    shift_e = 1; shift_c = 1;
    repeat (20) @(negedge clk);
    rst = 1;
    #1;
    chk("t6_rst_e_out", int'(reg_e_out), 0);
    chk("t6_rst_e_cnt", int'(reg_e_count), 0);
    chk("t6_rst_c_out", int'(reg_c_out), 0);
    chk("t6_rst_c_cnt", int'(reg_c_count), 0);
    shift_e = 0; shift_c = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    encode_check("t6");

    reg_e_in = 40'h12_3456_789a;
    shift_e = 1;
    repeat (10) @(negedge clk);
    chk("t6_mid_cnt", int'(reg_e_count), 9);
    shift_e = 0;
    @(negedge clk);
    shift_e = 1;
    @(negedge clk);
    chk("t6_restart_cnt", int'(reg_e_count), 0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
